// File: rtl/a0_trace_fifo.sv
// a0 change-trace FIFO: records each new value of a0 seen on an enabled cycle and drains it over valid/ready.
// Latency: a value pushed at edge N is on data_o/valid_o after edge N (first-word-fall-through from mem[rd_ptr]).
// Backpressure: ready_i low holds the head; a change arriving when full with no pop is dropped and sets sticky overflow_o.
//
// Ports:
//   clk, rst       : clock and synchronous active-high reset
//   a0_i           : a0 sample from the CPU register file
//   capture_en_i   : sample a0_i this cycle
//   data_o/valid_o : head entry (0 when empty) / FIFO non-empty
//   ready_i        : sink accepts the head entry
//   count_o        : current entry count, 0..DEPTH
//   overflow_o     : sticky trace-loss flag, cleared only by rst
//   ts_o           : head-entry timestamp, only when A0_TRACE_TS_EN is defined
//
// Optional feature macro: A0_TRACE_TS_EN adds a free-running TS_W-bit cycle
// counter whose value is stored with each entry and presented on ts_o.
module a0_trace_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int TS_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW-1:0]            a0_i,
  input  logic                     capture_en_i,
  output logic [DW-1:0]            data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
`ifdef A0_TRACE_TS_EN
  ,
  output logic [TS_W-1:0]          ts_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Pointer wrap relies on natural AW-bit rollover, so DEPTH must be a power of two.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("a0_trace_fifo: DEPTH must be a power of 2 and >= 2");
  end
  if (TS_W < 1) begin : g_bad_ts_w
    $error("a0_trace_fifo: TS_W must be >= 1");
  end

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [DW-1:0] last_a0;
  logic          last_vld;
  logic          overflow;

  logic full;
  logic push_req;
  logic push;
  logic pop;

  always_comb begin
    full     = (count == FULL_CNT);
    pop      = valid_o && ready_i;
    // last_vld=0 forces the first enabled sample after reset to push,
    // whatever last_a0 happens to hold.
    push_req = capture_en_i && (!last_vld || (a0_i != last_a0));
    // A pop in the same cycle frees the slot the push needs.
    push     = push_req && (!full || pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_a0  <= '0;
      last_vld <= 1'b0;
      overflow <= 1'b0;
    end else begin
      // The detector tracks what was sampled, not what was stored, so a
      // dropped value is not re-offered on the next cycle.
      if (capture_en_i) begin
        last_a0  <= a0_i;
        last_vld <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage carries no reset; stale contents are never visible because the
  // output is gated by valid_o.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= a0_i;
    end
  end

  assign valid_o    = (count != '0);
  assign data_o     = valid_o ? mem[rd_ptr] : '0;
  assign count_o    = count;
  assign overflow_o = overflow;

`ifdef A0_TRACE_TS_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      ts_mem[wr_ptr] <= ts_cnt;
    end
  end

  assign ts_o = valid_o ? ts_mem[rd_ptr] : '0;
`endif

endmodule

// File: tb/tb_a0_trace_fifo.sv
module tb_a0_trace_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef A0_TRACE_TS_EN
  localparam int TS_W  = 4;
`else
  localparam int TS_W  = 16;
`endif

  logic          clk;
  logic          rst;
  logic [DW-1:0] a0_i;
  logic          capture_en_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic [CW-1:0] count_o;
  logic          overflow_o;
`ifdef A0_TRACE_TS_EN
  logic [TS_W-1:0] ts_o;
`endif

  a0_trace_fifo #(.DW(DW), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .a0_i         (a0_i),
    .capture_en_i (capture_en_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .count_o      (count_o),
    .overflow_o   (overflow_o)
`ifdef A0_TRACE_TS_EN
    ,
    .ts_o         (ts_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard / reference model state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_last;
  bit            m_last_vld;
  bit            m_ovf;
  bit            pop_seen;
  logic [DW-1:0] pop_exp;
  logic [DW-1:0] pop_act;

  int n_chk  = 0;
  int n_fail = 0;

  // Drive one cycle of inputs, advance the model, and capture the head the
  // DUT presents in the cycle a pop is expected.
  task automatic drive(input bit en, input logic [DW-1:0] a0, input bit rdy);
    bit preq;
    bit mpop;
    @(negedge clk);
    capture_en_i = en;
    a0_i         = a0;
    ready_i      = rdy;
    mpop     = rdy && (exp_q.size() > 0);
    preq     = en && (!m_last_vld || (a0 != m_last));
    pop_seen = mpop;
    pop_act  = data_o;
    if (mpop) pop_exp = exp_q.pop_front();
    if (preq) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(a0);
      else m_ovf = 1'b1;
    end
    if (en) begin
      m_last     = a0;
      m_last_vld = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    capture_en_i = 1'b0;
    ready_i      = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_last_vld = 1'b0;
    m_last     = '0;
    m_ovf      = 1'b0;
    pop_seen   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; capture_en_i = 1'b0; a0_i = '0; ready_i = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();
    n_chk++;
    if (count_o !== '0 || valid_o !== 1'b0 || data_o !== '0 || overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: count=%0d valid=%b data=%0h ovf=%b, expected all zero",
               count_o, valid_o, data_o, overflow_o);
    end
  endtask

  task automatic test_hold_value();
    do_reset();
    repeat (10) drive(1'b1, 32'd5, 1'b0);
    n_chk++;
    if (count_o !== CW'(1) || valid_o !== 1'b1 || data_o !== 32'd5 || overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_value: count=%0d valid=%b data=%0d ovf=%b, expected 1/1/5/0",
               count_o, valid_o, data_o, overflow_o);
    end
  endtask

  task automatic test_dedup_drain();
    logic [DW-1:0] seq [4] = '{32'd1, 32'd2, 32'd2, 32'd3};
    do_reset();
    foreach (seq[i]) drive(1'b1, seq[i], 1'b0);
    n_chk++;
    if (count_o !== CW'(3)) begin
      n_fail++;
      $display("FAIL dedup_count: count=%0d expected 3", count_o);
    end
    repeat (3) begin
      drive(1'b0, '0, 1'b1);
      if (pop_seen) begin
        n_chk++;
        if (pop_act !== pop_exp) begin
          n_fail++;
          $display("FAIL dedup_drain: data=%0d expected %0d", pop_act, pop_exp);
        end
      end
    end
    n_chk++;
    if (valid_o !== 1'b0 || data_o !== '0) begin
      n_fail++;
      $display("FAIL dedup_empty: valid=%b data=%0h expected 0/0", valid_o, data_o);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int v = 1; v <= 5; v++) drive(1'b1, DW'(v), 1'b0);
    n_chk++;
    if (count_o !== CW'(DEPTH) || overflow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_full: count=%0d ovf=%b expected %0d/1", count_o, overflow_o, DEPTH);
    end
    repeat (DEPTH) begin
      drive(1'b0, '0, 1'b1);
      if (pop_seen) begin
        n_chk++;
        if (pop_act !== pop_exp) begin
          n_fail++;
          $display("FAIL overflow_drain: data=%0d expected %0d", pop_act, pop_exp);
        end
      end
    end
    n_chk++;
    if (valid_o !== 1'b0 || overflow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky: valid=%b ovf=%b expected 0/1", valid_o, overflow_o);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int v = 1; v <= DEPTH; v++) drive(1'b1, DW'(v), 1'b0);
    drive(1'b1, 32'd9, 1'b1);
    n_chk++;
    if (pop_act !== pop_exp) begin
      n_fail++;
      $display("FAIL full_pushpop_head: data=%0d expected %0d", pop_act, pop_exp);
    end
    n_chk++;
    if (count_o !== CW'(DEPTH) || overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pushpop: count=%0d ovf=%b expected %0d/0", count_o, overflow_o, DEPTH);
    end
    repeat (DEPTH) begin
      drive(1'b0, '0, 1'b1);
      if (pop_seen) begin
        n_chk++;
        if (pop_act !== pop_exp) begin
          n_fail++;
          $display("FAIL full_pushpop_drain: data=%0d expected %0d", pop_act, pop_exp);
        end
      end
    end
  endtask

  task automatic test_enable_gating();
    do_reset();
    drive(1'b1, 32'd7, 1'b0);
    drive(1'b0, 32'd8, 1'b0);
    drive(1'b0, 32'd9, 1'b0);
    drive(1'b1, 32'd7, 1'b0);
    n_chk++;
    if (count_o !== CW'(1) || data_o !== 32'd7) begin
      n_fail++;
      $display("FAIL enable_gating: count=%0d data=%0d expected 1/7", count_o, data_o);
    end
    drive(1'b1, 32'd8, 1'b0);
    n_chk++;
    if (count_o !== CW'(exp_q.size()) || count_o !== CW'(2)) begin
      n_fail++;
      $display("FAIL enable_new_value: count=%0d expected 2", count_o);
    end
    repeat (2) begin
      drive(1'b0, '0, 1'b1);
      if (pop_seen) begin
        n_chk++;
        if (pop_act !== pop_exp) begin
          n_fail++;
          $display("FAIL enable_drain: data=%0d expected %0d", pop_act, pop_exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int v = 1; v <= 5; v++) drive(1'b1, DW'(v), 1'b0);
    drive(1'b0, '0, 1'b1);
    n_chk++;
    if (count_o !== CW'(3) || overflow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_pre: count=%0d ovf=%b expected 3/1", count_o, overflow_o);
    end
    do_reset();
    n_chk++;
    if (count_o !== '0 || valid_o !== 1'b0 || overflow_o !== 1'b0 || data_o !== '0) begin
      n_fail++;
      $display("FAIL midreset_clear: count=%0d valid=%b ovf=%b data=%0h expected zeros",
               count_o, valid_o, overflow_o, data_o);
    end
    drive(1'b1, 32'd5, 1'b0);
    n_chk++;
    if (count_o !== CW'(1) || data_o !== 32'd5) begin
      n_fail++;
      $display("FAIL midreset_resample: count=%0d data=%0d expected 1/5", count_o, data_o);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, DW'(i * 3), 1'b1);
      if (pop_seen) begin
        n_chk++;
        if (pop_act !== pop_exp) begin
          n_fail++;
          $display("FAIL b2b_data: data=%0d expected %0d", pop_act, pop_exp);
        end
      end
      n_chk++;
      if (count_o !== CW'(exp_q.size())) begin
        n_fail++;
        $display("FAIL b2b_count: count=%0d expected %0d", count_o, exp_q.size());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, DW'($urandom % 3), ($urandom % 3) == 0);
      if (pop_seen) begin
        n_chk++;
        if (pop_act !== pop_exp) begin
          n_fail++;
          $display("FAIL rand_data: cycle %0d data=%0d expected %0d", i, pop_act, pop_exp);
        end
      end
      n_chk++;
      if (count_o !== CW'(exp_q.size()) || overflow_o !== m_ovf) begin
        n_fail++;
        $display("FAIL rand_state: cycle %0d count=%0d ovf=%b expected %0d/%b",
                 i, count_o, overflow_o, exp_q.size(), m_ovf);
      end
    end
  endtask

`ifdef A0_TRACE_TS_EN
  task automatic test_timestamp();
    do_reset();
    // Counter is 0 on the first edge after reset, so the third edge stores 2.
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    drive(1'b1, 32'd11, 1'b0);
    n_chk++;
    if (ts_o !== TS_W'(2)) begin
      n_fail++;
      $display("FAIL ts_first: ts=%0d expected 2", ts_o);
    end
    drive(1'b0, '0, 1'b1);
    n_chk++;
    if (ts_o !== '0) begin
      n_fail++;
      $display("FAIL ts_empty: ts=%0d expected 0", ts_o);
    end
    repeat (14) drive(1'b0, '0, 1'b0);
    drive(1'b1, 32'd12, 1'b0);
    n_chk++;
    if (ts_o !== TS_W'(18 % 16)) begin
      n_fail++;
      $display("FAIL ts_wrap: ts=%0d expected 2", ts_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_hold_value();
    test_dedup_drain();
    test_overflow();
    test_full_push_pop();
    test_enable_gating();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef A0_TRACE_TS_EN
    test_timestamp();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
